// File: rtl/dm_lsu.sv
// Load/store initiator for the negedge-clocked 256x32 data memory: byte/half/word
// requests, read-modify-write for sub-word stores, sign/zero-extended loads.
module dm_lsu #(
  parameter int unsigned DM_AW = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [DM_AW+1:0]   req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [DM_AW-1:0]   dm_address,
  output logic [31:0]        dm_data,
  output logic               dm_rden,
  output logic               dm_wren,
  input  logic [31:0]        dm_q
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t             state_q;
  logic               we_q;
  logic               uns_q;
  logic [1:0]         size_q;
  logic [1:0]         lane_q;
  logic [31:0]        wdata_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [31:0]        rsp_rdata_q;
  logic [DM_AW-1:0]   dm_address_q;
  logic [31:0]        dm_data_q;
  logic               dm_rden_q;
  logic               dm_wren_q;

  logic               req_err;
  logic               need_read;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_d;
  logic [31:0]        merge_d;

  always_comb begin
    req_err = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    // Loads and sub-word stores both start with a memory read.
    need_read = !req_we || (req_size != 2'b10);
  end

  always_comb begin
    byte_sel = dm_q[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? dm_q[31:16] : dm_q[15:0];
    case (size_q)
      2'b00:   load_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_d = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_d = dm_q;
    endcase
    merge_d = dm_q;
    case (size_q)
      2'b00: merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (lane_q[1]) merge_d[31:16] = wdata_q[15:0];
        else           merge_d[15:0]  = wdata_q[15:0];
      end
      default: merge_d = wdata_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      dm_address_q <= '0;
      dm_data_q    <= '0;
      dm_rden_q    <= 1'b0;
      dm_wren_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            uns_q        <= req_unsigned;
            size_q       <= req_size;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata;
            req_ready_q  <= 1'b0;
            dm_address_q <= req_addr[DM_AW+1:2];
            if (req_err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end else if (need_read) begin
              dm_rden_q <= 1'b1;
              state_q   <= READ;
            end else begin
              dm_data_q <= req_wdata;
              dm_wren_q <= 1'b1;
              state_q   <= WRITE;
            end
          end
        end
        READ: begin
          dm_rden_q <= 1'b0;
          if (we_q) begin
            dm_data_q <= merge_d;
            dm_wren_q <= 1'b1;
            state_q   <= WRITE;
          end else begin
            rsp_rdata_q <= load_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WRITE: begin
          dm_wren_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign dm_address = dm_address_q;
  assign dm_data    = dm_data_q;
  assign dm_rden    = dm_rden_q;
  assign dm_wren    = dm_wren_q;

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store initiator that drives the word-addressed data memory (negedge-clocked, 256 × 32, registered `q`, separate `rden`/`wren`) on behalf of the core. It accepts byte/half/word requests on a valid/ready interface, performs read-modify-write for sub-word stores (the memory has no byte enables), sign- or zero-extends loads, and returns one response per request. It sits between the core's MEM stage and the data memory instance.

## Interface
- `DM_AW`, 8, data-memory word-address width; the byte address is `DM_AW+2` bits.
- `clock`  in  1  single clock; all block state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  DM_AW+2  byte address; `[DM_AW+1:2]` word, `[1:0]` lane.
- `req_wdata`  in  32  store data, right-aligned (byte in `[7:0]`, half in `[15:0]`).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core accepts response.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  illegal size or misaligned address.
- `dm_address`  out  DM_AW  to memory `address`.
- `dm_data`  out  32  to memory `data`.
- `dm_rden`  out  1  to memory `rden`.
- `dm_wren`  out  1  to memory `wren`.
- `dm_q`  in  32  from memory `q`.

## Operation
- Little-endian lanes: lane 0 = bits `[7:0]`, lane 3 = `[31:24]`; half at lane 0 = `[15:0]`, lane 2 = `[31:16]`.
- Alignment: half needs `addr[0]=0`; word needs `addr[1:0]=0`. `req_size=11` is illegal regardless of address.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: `req_ready=1`. On `req_valid`: latch request; error → RESP (err); load → READ; word store → WRITE with `dm_data=req_wdata`; byte/half store → READ.
  - READ: `dm_rden=1`, `dm_address`=word. At cycle end `dm_q` is valid. Load: register extracted, extended lane into `rsp_rdata`, → RESP. Sub-word store: register `dm_q` with target lane(s) replaced by `req_wdata` into `dm_data`, → WRITE.
  - WRITE: `dm_wren=1` for exactly one cycle, → RESP.
  - RESP: `rsp_valid=1`, outputs held stable until `rsp_ready`; then → IDLE.
- `dm_rden` and `dm_wren` are never both 1; neither is asserted for error requests.
- Exactly one response per accepted request, in order; no new request accepted until the response handshake completes.
- Reset values: state IDLE, `req_ready=1` from the first cycle after reset, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `dm_rden=0`, `dm_wren=0`, `dm_address=0`, `dm_data=0`.

## Timing
- Cycle k is the interval after posedge k; request accepted at posedge 0.
- Memory handshake: strobes/address/data are stable from posedge k; memory samples at the following negedge; `dm_q` is sampled at posedge k+1.
- Latency to `rsp_valid` (first cycle): error → cycle 1; word store → cycle 2 (WRITE in 1); load → cycle 2 (READ in 1); byte/half store → cycle 3 (READ 1, WRITE 2).
- With `rsp_ready` held high, throughput is one request per (latency+1) cycles; the next request can be accepted in the cycle after the response handshake.
- Backpressure: `rsp_ready` low holds RESP indefinitely; `req_ready` stays 0.
- Reset mid-operation: `rst` sampled high at any posedge forces IDLE and clears all outputs at that edge; a `dm_wren` already driven in the current cycle completes at its negedge; the pending response is dropped.
- `rsp_valid` and `rsp_ready` both high in the same cycle completes the handshake at that posedge.

## Test plan
- Word store 0xDEADBEEF @0x010, then word load @0x010 → `rsp_rdata=0xDEADBEEF`; store response in cycle 2 with `dm_wren` high in cycle 1 only.
- Word 0x11223344 @0x010, then byte store 0xA5 @0x013 → memory word 0xA5223344; READ→WRITE sequence with `dm_rden` in cycle 1 and `dm_wren` in cycle 2.
- Byte load @0x013: signed → 0xFFFFFFA5; unsigned → 0x000000A5. Half load @0x012, signed → 0xFFFFA522.
- Half store @0x011, word load @0x012, `req_size=11` → each gives `rsp_err=1`, `rsp_rdata=0`, response in cycle 1, and no `dm_rden`/`dm_wren` pulse.
- Load with `rsp_ready` low for 3 cycles → `rsp_valid` and `rsp_rdata` stable for 4 cycles; `req_ready=0` throughout; `req_valid` presented meanwhile is not accepted.
- `rst` asserted during READ of a byte store → no `dm_wren` pulse, memory word unchanged, no response, `req_ready=1` in the cycle after reset.
